// File: rtl/im_loader.sv
// Instruction-memory program loader: packs a byte stream into
// little-endian 32-bit words and writes them from address 0 upward.
module im_loader #(
  parameter int DEPTH_BYTES = 32,
  parameter int CNT_W       = $clog2(DEPTH_BYTES/4)+1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_load_words,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_valid,
  output logic             o_rx_ready,
  output logic             o_wr_en,
  output logic [63:0]      o_wr_addr,
  output logic [31:0]      o_wr_data,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [31:0]      o_checksum
);

  localparam int MAX_WORDS = DEPTH_BYTES/4;
  localparam logic [CNT_W-1:0] W_MAX = CNT_W'(MAX_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_FIN
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_word_idx;
  logic [1:0]       r_byte_idx;
  logic [23:0]      r_buf;
  logic             r_rx_ready;
  logic             r_wr_en;
  logic [63:0]      r_wr_addr;
  logic [31:0]      r_wr_data;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [31:0]      r_checksum;

  logic             w_hs;
  logic [CNT_W-1:0] w_next_idx;
  logic [63:0]      w_addr;

  assign w_hs       = i_rx_valid & r_rx_ready;
  assign w_next_idx = r_word_idx + CNT_W'(1);
  assign w_addr     = {{(62-CNT_W){1'b0}}, r_word_idx, 2'b00};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_word_idx <= '0;
      r_byte_idx <= '0;
      r_buf      <= '0;
      r_rx_ready <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_checksum <= '0;
    end else begin
      r_err <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (i_load_words == '0) begin
              r_checksum <= '0;
              r_done     <= 1'b1;
              r_busy     <= 1'b1;
              r_state    <= S_FIN;
            end else if (i_load_words > W_MAX) begin
              r_err <= 1'b1;
            end else begin
              r_count    <= i_load_words;
              r_word_idx <= '0;
              r_byte_idx <= '0;
              r_checksum <= '0;
              r_rx_ready <= 1'b1;
              r_busy     <= 1'b1;
              r_state    <= S_COLLECT;
            end
          end
        end
        S_COLLECT: begin
          if (w_hs) begin
            r_byte_idx <= r_byte_idx + 2'd1;
            unique case (r_byte_idx)
              2'd0: r_buf[7:0]   <= i_rx_data;
              2'd1: r_buf[15:8]  <= i_rx_data;
              2'd2: r_buf[23:16] <= i_rx_data;
              2'd3: begin
                // Lane 3 completes the word; present it straight to the write port.
                r_wr_data  <= {i_rx_data, r_buf};
                r_wr_addr  <= w_addr;
                r_wr_en    <= 1'b1;
                r_rx_ready <= 1'b0;
                r_state    <= S_WRITE;
              end
            endcase
          end
        end
        S_WRITE: begin
          r_wr_en    <= 1'b0;
          r_checksum <= r_checksum ^ r_wr_data;
          r_word_idx <= w_next_idx;
          if (w_next_idx == r_count) begin
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end else begin
            r_rx_ready <= 1'b1;
            r_state    <= S_COLLECT;
          end
        end
        S_FIN: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_rx_ready = r_rx_ready;
  assign o_wr_en    = r_wr_en;
  assign o_wr_addr  = r_wr_addr;
  assign o_wr_data  = r_wr_data;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_checksum = r_checksum;

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: reset, single/full loads,
// range checks, busy rules and mid-load reset.
module tb_im_loader;

  localparam int DB = 32;
  localparam int CW = $clog2(DB/4)+1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] load_words;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          wr_en;
  logic [63:0]   wr_addr;
  logic [31:0]   wr_data;
  logic          busy;
  logic          done;
  logic          err;
  logic [31:0]   checksum;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] wa [0:63];
  logic [31:0] wd [0:63];
  int wcnt = 0;
  int dcnt = 0;
  int ecnt = 0;

  logic [31:0] words [0:7];
  logic [31:0] xsum;
  int base;
  int dbase;
  int ebase;

  always #5 clk = ~clk;

  im_loader #(.DEPTH_BYTES(DB), .CNT_W(CW)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_start(start),
    .i_load_words(load_words),
    .i_rx_data(rx_data),
    .i_rx_valid(rx_valid),
    .o_rx_ready(rx_ready),
    .o_wr_en(wr_en),
    .o_wr_addr(wr_addr),
    .o_wr_data(wr_data),
    .o_busy(busy),
    .o_done(done),
    .o_err(err),
    .o_checksum(checksum)
  );

  always @(posedge clk) begin
    if (wr_en === 1'b1 && wcnt < 64) begin
      wa[wcnt] = wr_addr;
      wd[wcnt] = wr_data;
      wcnt = wcnt + 1;
    end
    if (done === 1'b1) dcnt = dcnt + 1;
    if (err === 1'b1) ecnt = ecnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [CW-1:0] n);
    start = 1'b1;
    load_words = n;
    tick();
    start = 1'b0;
    load_words = '0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    logic hs;
    int k;
    rx_valid = 1'b0;
    for (int g = 0; g < gap; g++) tick();
    rx_valid = 1'b1;
    rx_data = b;
    hs = 1'b0;
    k = 0;
    while (!hs && k < 20) begin
      @(posedge clk);
      hs = rx_ready;
      #1;
      k++;
    end
    rx_valid = 1'b0;
    if (!hs) chk("send_timeout", 64'(hs), 64'd1);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (done !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk("done_seen", 64'(done), 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    load_words = '0;
    rx_data = '0;
    rx_valid = 1'b0;
    words[0] = 32'hD2800013; words[1] = 32'h00A00093;
    words[2] = 32'h12345678; words[3] = 32'hDEADBEEF;
    words[4] = 32'h0000006F; words[5] = 32'hFFFFFFFF;
    words[6] = 32'h80000001; words[7] = 32'hCAFEF00D;

    tick(); tick();
    rst = 1'b0;
    chk("rst_rx_ready", 64'(rx_ready), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_addr", wr_addr, 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_checksum", 64'(checksum), 64'd0);

    // single word, back-to-back bytes
    base = wcnt;
    pulse_start(CW'(1));
    chk("s1_rx_ready", 64'(rx_ready), 64'd1);
    chk("s1_busy", 64'(busy), 64'd1);
    send(8'h13, 0); send(8'h00, 0); send(8'h80, 0); send(8'hD2, 0);
    chk("s1_wr_en", 64'(wr_en), 64'd1);
    chk("s1_rx_ready_wr", 64'(rx_ready), 64'd0);
    chk("s1_wr_addr", wr_addr, 64'd0);
    chk("s1_wr_data", 64'(wr_data), 64'hD2800013);
    tick();
    chk("s1_done", 64'(done), 64'd1);
    chk("s1_wr_en_off", 64'(wr_en), 64'd0);
    chk("s1_checksum", 64'(checksum), 64'hD2800013);
    tick();
    chk("s1_done_off", 64'(done), 64'd0);
    chk("s1_busy_off", 64'(busy), 64'd0);
    chk("s1_nwrites", 64'(wcnt - base), 64'd1);

    // full load with gaps and an ignored mid-load START
    base = wcnt;
    ebase = ecnt;
    dbase = dcnt;
    xsum = '0;
    pulse_start(CW'(8));
    for (int w = 0; w < 8; w++) begin
      for (int b = 0; b < 4; b++) begin
        send(words[w][8*b +: 8], int'($urandom_range(0, 2)));
        if (w == 2 && b == 1) begin
          pulse_start(CW'(2));
          pulse_start(CW'(15));
        end
      end
      xsum = xsum ^ words[w];
    end
    wait_done();
    chk("f8_checksum", 64'(checksum), 64'(xsum));
    tick();
    chk("f8_busy_off", 64'(busy), 64'd0);
    chk("f8_nwrites", 64'(wcnt - base), 64'd8);
    chk("f8_no_err", 64'(ecnt - ebase), 64'd0);
    chk("f8_one_done", 64'(dcnt - dbase), 64'd1);
    for (int w = 0; w < 8; w++) begin
      chk($sformatf("f8_addr%0d", w), wa[base + w], 64'(4 * w));
      chk($sformatf("f8_data%0d", w), 64'(wd[base + w]), 64'(words[w]));
    end
    rx_valid = 1'b1;
    rx_data = 8'hAA;
    for (int k = 0; k < 3; k++) begin
      chk("extra_rx_ready", 64'(rx_ready), 64'd0);
      tick();
    end
    rx_valid = 1'b0;
    chk("extra_nwrites", 64'(wcnt - base), 64'd8);

    // range check: too many words
    base = wcnt;
    pulse_start(CW'(9));
    chk("r9_err", 64'(err), 64'd1);
    chk("r9_busy", 64'(busy), 64'd0);
    tick();
    chk("r9_err_off", 64'(err), 64'd0);
    chk("r9_checksum_held", 64'(checksum), 64'(xsum));
    chk("r9_nwrites", 64'(wcnt - base), 64'd0);

    // zero-word load
    pulse_start(CW'(0));
    chk("r0_done", 64'(done), 64'd1);
    chk("r0_busy", 64'(busy), 64'd1);
    chk("r0_checksum", 64'(checksum), 64'd0);
    tick();
    chk("r0_done_off", 64'(done), 64'd0);
    chk("r0_busy_off", 64'(busy), 64'd0);
    chk("r0_nwrites", 64'(wcnt - base), 64'd0);

    // mid-load reset after 6 bytes
    base = wcnt;
    dbase = dcnt;
    pulse_start(CW'(8));
    for (int b = 0; b < 6; b++) send(8'(b + 1), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_rx_ready", 64'(rx_ready), 64'd0);
    rx_valid = 1'b1;
    rx_data = 8'h55;
    for (int k = 0; k < 6; k++) tick();
    rx_valid = 1'b0;
    chk("mr_nwrites", 64'(wcnt - base), 64'd1);
    chk("mr_no_done", 64'(dcnt - dbase), 64'd0);

    base = wcnt;
    pulse_start(CW'(1));
    send(8'h11, 0); send(8'h22, 1); send(8'h33, 0); send(8'h44, 2);
    wait_done();
    chk("pr_nwrites", 64'(wcnt - base), 64'd1);
    chk("pr_addr", wa[base], 64'd0);
    chk("pr_data", 64'(wd[base]), 64'h44332211);
    chk("pr_checksum", 64'(checksum), 64'h44332211);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
